regfile_mp: RTL and testbench

Parametrised multi-port integer register file: the next-generation replacement for the single-write, two-read core register file. It provides configurable width, depth and read-port count, two write ports with fixed priority, optional write-to-read bypass and an optional hardwired zero register. A sequencer zeroes the storage after reset or on request, with a ready indication. It sits between the decode stage (read addresses) and the writeback stage (write ports) of the pipeline.

---
 rtl/regfile_pkg.sv | 15 +
 rtl/regfile_mp_if.sv | 45 ++++
 rtl/regfile_read_port.sv | 42 ++++
 rtl/regfile_mp.sv | 109 ++++++++++
 tb/tb_regfile_mp.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Imported by the interface, the read lane and the top level.
package regfile_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_t;

  // Address width for a register count; a 2-entry file still needs one bit.
  function automatic int rf_addr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback bus of the multi-port register file: read lanes, two
// write ports, clear request and status.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
) ();

  localparam int ADDR_W = rf_addr_w(DEPTH);

  logic [NUM_RD*ADDR_W-1:0] rd_addr_i;
  logic [NUM_RD*DATA_W-1:0] rd_data_o;

  logic              wr0_en_i;
  logic [ADDR_W-1:0] wr0_addr_i;
  logic [DATA_W-1:0] wr0_data_i;

  logic              wr1_en_i;
  logic [ADDR_W-1:0] wr1_addr_i;
  logic [DATA_W-1:0] wr1_data_i;

  logic clear_i;
  logic ready_o;
  logic wr_conflict_o;

  // Pipeline side: decode/writeback drive addresses and writes.
  modport master (
    output rd_addr_i,
    output wr0_en_i, wr0_addr_i, wr0_data_i,
    output wr1_en_i, wr1_addr_i, wr1_data_i,
    output clear_i,
    input  rd_data_o, ready_o, wr_conflict_o
  );

  modport slave (
    input  rd_addr_i,
    input  wr0_en_i, wr0_addr_i, wr0_data_i,
    input  wr1_en_i, wr1_addr_i, wr1_data_i,
    input  clear_i,
    output rd_data_o, ready_o, wr_conflict_o
  );

endinterface

// File: rtl/regfile_read_port.sv
// One combinational read lane: zero-register check, write bypass with port 1
// ahead of port 0, then the storage value.
module regfile_read_port #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic              force_zero,
  input  logic [ADDR_W-1:0] addr,
  input  logic              we0,
  input  logic [ADDR_W-1:0] waddr0,
  input  logic [DATA_W-1:0] wdata0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] waddr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic [DATA_W-1:0] mem [DEPTH],
  output logic [DATA_W-1:0] data
);

  logic is_zero_reg;

  assign is_zero_reg = (ZERO_REG != 0) && (addr == '0);

  always_comb begin
    // NOTE: assigning a default before any branch keeps this block free of latches.
    data = mem[addr];
    if (BYPASS != 0) begin
      if (we1 && (waddr1 == addr)) begin
        data = wdata1;
      end else if (we0 && (waddr0 == addr)) begin
        data = wdata0;
      end
    end
    // Storage is not valid while the clear pass runs.
    if (is_zero_reg || force_zero) begin
      data = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file top: storage array, two prioritised write ports,
// post-reset/on-demand clear sequencer and the write-conflict flag.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic         clock_i,
  input  logic         reset_ni,
  regfile_mp_if.slave  bus
);

  localparam int                ADDR_W    = rf_addr_w(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rf_state_t         state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              ready_q;
  logic              conflict_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic we0;
  logic we1;
  logic same_addr;
  logic wr0_go;
  logic wr1_go;

  // Effective enables: writes aimed at the hardwired zero register vanish.
  assign we0       = bus.wr0_en_i && !((ZERO_REG != 0) && (bus.wr0_addr_i == '0));
  assign we1       = bus.wr1_en_i && !((ZERO_REG != 0) && (bus.wr1_addr_i == '0));
  assign same_addr = (bus.wr0_addr_i == bus.wr1_addr_i);

  // Port 1 wins a same-address collision, so port 0 simply steps aside.
  assign wr0_go = (state == RF_READY) && we0 && !(we1 && same_addr);
  assign wr1_go = (state == RF_READY) && we1;

  // NOTE: the storage array has no reset; the clear sequencer zeroes it instead.
  always_ff @(posedge clock_i) begin
    if (state == RF_CLEAR) begin
      mem[clr_cnt] <= '0;
    end else begin
      if (wr0_go) mem[bus.wr0_addr_i] <= bus.wr0_data_i;
      if (wr1_go) mem[bus.wr1_addr_i] <= bus.wr1_data_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= RF_CLEAR;
      clr_cnt    <= '0;
      ready_q    <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      case (state)
        RF_CLEAR: begin
          conflict_q <= 1'b0;
          if (clr_cnt == LAST_ADDR) begin
            state   <= RF_READY;
            ready_q <= 1'b1;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        RF_READY: begin
          conflict_q <= we0 && we1 && same_addr;
          // Writes in the clear-request cycle still commit; the pass wipes them.
          if (bus.clear_i) begin
            state   <= RF_CLEAR;
            ready_q <= 1'b0;
            clr_cnt <= '0;
          end
        end
      endcase
    end
  end

  assign bus.ready_o       = ready_q;
  assign bus.wr_conflict_o = conflict_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .BYPASS   (BYPASS),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .force_zero (state != RF_READY),
      .addr       (bus.rd_addr_i[k*ADDR_W +: ADDR_W]),
      .we0        (we0),
      .waddr0     (bus.wr0_addr_i),
      .wdata0     (bus.wr0_data_i),
      .we1        (we1),
      .waddr1     (bus.wr1_addr_i),
      .wdata1     (bus.wr1_data_i),
      .mem        (mem),
      .data       (bus.rd_data_o[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench: a 32x32 two-lane bypassing file against a reference
// model, plus a 16x64 four-lane non-bypassing file with directed checks.
module tb_regfile_mp;
  import regfile_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_mp_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) bus_a ();
  regfile_mp_if #(.DATA_W(64), .DEPTH(16), .NUM_RD(4)) bus_b ();

  regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) u_dut_a (
    .clock_i (clk),
    .reset_ni(rst_n),
    .bus     (bus_a.slave)
  );

  regfile_mp #(.DATA_W(64), .DEPTH(16), .NUM_RD(4), .BYPASS(0), .ZERO_REG(0)) u_dut_b (
    .clock_i (clk),
    .reset_ni(rst_n),
    .bus     (bus_b.slave)
  );

  int tests = 0;
  int fails = 0;

  // Reference model of file A: register contents, remaining clear cycles,
  // and the conflict flag expected after the last edge.
  logic [31:0] mdl [32];
  int          clear_left;
  bit          exp_conf;
  logic [4:0]  ra [2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input bit en0, input logic [4:0] a0, input logic [31:0] d0,
                         input bit en1, input logic [4:0] a1, input logic [31:0] d1,
                         input bit clr);
    bus_a.wr0_en_i   = en0;
    bus_a.wr0_addr_i = a0;
    bus_a.wr0_data_i = d0;
    bus_a.wr1_en_i   = en1;
    bus_a.wr1_addr_i = a1;
    bus_a.wr1_data_i = d1;
    bus_a.clear_i    = clr;
  endtask

  task automatic idle_a();
    drive_a(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
  endtask

  task automatic set_ra(input logic [4:0] r0, input logic [4:0] r1);
    ra[0] = r0;
    ra[1] = r1;
    bus_a.rd_addr_i = {r1, r0};
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    bit e0;
    bit e1;
    e0 = bus_a.wr0_en_i && (bus_a.wr0_addr_i != 5'd0);
    e1 = bus_a.wr1_en_i && (bus_a.wr1_addr_i != 5'd0);
    if (clear_left != 0) return 32'd0;
    if (a == 5'd0) return 32'd0;
    if (e1 && bus_a.wr1_addr_i == a) return bus_a.wr1_data_i;
    if (e0 && bus_a.wr0_addr_i == a) return bus_a.wr0_data_i;
    return mdl[a];
  endfunction

  task automatic model_reset();
    clear_left = 32;
    exp_conf   = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
  endtask

  // Called at a falling edge with inputs already applied; checks A, crosses
  // one rising edge, updates the model and returns at the next falling edge.
  task automatic cycle_a();
    bit e0;
    bit e1;
    #1;
    for (int k = 0; k < 2; k++)
      check($sformatf("rd_lane%0d_r%0d", k, ra[k]), 64'(bus_a.rd_data_o[k*32 +: 32]),
            64'(exp_read(ra[k])));
    check("ready_a", 64'(bus_a.ready_o), 64'(clear_left == 0));
    check("conflict_a", 64'(bus_a.wr_conflict_o), 64'(exp_conf));
    @(posedge clk);
    e0 = bus_a.wr0_en_i && (bus_a.wr0_addr_i != 5'd0);
    e1 = bus_a.wr1_en_i && (bus_a.wr1_addr_i != 5'd0);
    if (clear_left == 0) begin
      exp_conf = e0 && e1 && (bus_a.wr0_addr_i == bus_a.wr1_addr_i);
      if (e0) mdl[bus_a.wr0_addr_i] = bus_a.wr0_data_i;
      if (e1) mdl[bus_a.wr1_addr_i] = bus_a.wr1_data_i;
      if (bus_a.clear_i) begin
        clear_left = 32;
        for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
      end
    end else begin
      exp_conf = 1'b0;
      clear_left--;
    end
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    check("rst_ready_a", 64'(bus_a.ready_o), 64'd0);
    check("rst_conflict_a", 64'(bus_a.wr_conflict_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish within cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] vb [16];

    idle_a();
    set_ra(5'd0, 5'd0);
    bus_b.rd_addr_i  = '0;
    bus_b.wr0_en_i   = 1'b0;
    bus_b.wr0_addr_i = '0;
    bus_b.wr0_data_i = '0;
    bus_b.wr1_en_i   = 1'b0;
    bus_b.wr1_addr_i = '0;
    bus_b.wr1_data_i = '0;
    bus_b.clear_i    = 1'b0;

    // Reset and the initial clear pass: not ready for 32 cycles, then all zero.
    @(negedge clk);
    reset_pulse();
    for (int i = 0; i < 32; i++) begin
      set_ra(5'(i), 5'(31 - i));
      cycle_a();
    end
    for (int i = 0; i < 32; i++) begin
      set_ra(5'(i), 5'(i ^ 1));
      cycle_a();
    end

    // Same-cycle bypass, then visibility through storage.
    drive_a(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0);
    set_ra(5'd0, 5'd5);
    #1 check("bypass_r5_same", 64'(bus_a.rd_data_o[63:32]), 64'hDEADBEEF);
    cycle_a();
    idle_a();
    #1 check("r5_next", 64'(bus_a.rd_data_o[63:32]), 64'hDEADBEEF);
    cycle_a();

    // Same-address collision: port 1 wins and the conflict flag pulses once.
    drive_a(1'b1, 5'd7, 32'h11, 1'b1, 5'd7, 32'h22, 1'b0);
    set_ra(5'd7, 5'd5);
    cycle_a();
    idle_a();
    #1 check("r7_after_conflict", 64'(bus_a.rd_data_o[31:0]), 64'h22);
    check("conflict_pulse", 64'(bus_a.wr_conflict_o), 64'd1);
    cycle_a();
    #1 check("conflict_gone", 64'(bus_a.wr_conflict_o), 64'd0);
    cycle_a();
    drive_a(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22, 1'b0);
    set_ra(5'd0, 5'd7);
    cycle_a();
    idle_a();
    #1 check("r0_conflict_none", 64'(bus_a.wr_conflict_o), 64'd0);
    check("r0_stays_zero", 64'(bus_a.rd_data_o[31:0]), 64'd0);
    cycle_a();

    // Clear request with a same-cycle write; writes offered mid-clear are lost.
    drive_a(1'b1, 5'd3, 32'h55, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle_a();
    drive_a(1'b1, 5'd4, 32'h66, 1'b0, 5'd0, 32'd0, 1'b1);
    set_ra(5'd4, 5'd3);
    #1 check("r3_before_clear", 64'(bus_a.rd_data_o[63:32]), 64'h55);
    cycle_a();
    for (int i = 0; i < 32; i++) begin
      if (i == 10) drive_a(1'b1, 5'd3, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0);
      else idle_a();
      cycle_a();
    end
    idle_a();
    set_ra(5'd3, 5'd4);
    #1 check("r3_cleared", 64'(bus_a.rd_data_o[31:0]), 64'd0);
    check("r4_cleared", 64'(bus_a.rd_data_o[63:32]), 64'd0);
    check("ready_after_clear", 64'(bus_a.ready_o), 64'd1);
    cycle_a();

    // Reset mid-clear (counter at 17) restarts the full pass.
    drive_a(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle_a();
    idle_a();
    for (int i = 0; i < 17; i++) cycle_a();
    reset_pulse();
    for (int i = 0; i < 33; i++) begin
      set_ra(5'($urandom_range(31)), 5'($urandom_range(31)));
      cycle_a();
    end

    // Randomised traffic with a narrow address range to provoke collisions.
    for (int i = 0; i < 400; i++) begin
      logic [4:0] mask;
      mask = (i % 3 == 0) ? 5'h03 : 5'h1F;
      drive_a(1'($urandom), 5'($urandom) & mask, $urandom,
              1'($urandom), 5'($urandom) & mask, $urandom,
              ($urandom_range(59) == 0));
      set_ra(5'($urandom) & mask, 5'($urandom) & mask);
      cycle_a();
    end
    idle_a();

    // File B: four simultaneous 64-bit reads, no bypass, no zero register.
    check("ready_b", 64'(bus_b.ready_o), 64'd1);
    for (int i = 0; i < 16; i++) vb[i] = {$urandom, $urandom & 32'hFFFF_FFF0 | 32'(i)};
    for (int i = 0; i < 4; i++) begin
      bus_b.wr0_en_i   = 1'b1;
      bus_b.wr0_addr_i = 4'(i);
      bus_b.wr0_data_i = vb[i];
      bus_b.rd_addr_i  = {4'd0, 4'd0, 4'd0, 4'(i)};
      #1 check($sformatf("b_nobypass_r%0d", i), bus_b.rd_data_o[63:0], 64'd0);
      @(negedge clk);
    end
    bus_b.wr0_en_i  = 1'b0;
    bus_b.rd_addr_i = {4'd3, 4'd2, 4'd1, 4'd0};
    #1;
    for (int k = 0; k < 4; k++)
      check($sformatf("b_lane%0d", k), bus_b.rd_data_o[k*64 +: 64], vb[k]);
    @(negedge clk);
    bus_b.wr0_en_i   = 1'b1;
    bus_b.wr0_addr_i = 4'd15;
    bus_b.wr0_data_i = vb[15];
    bus_b.wr1_en_i   = 1'b1;
    bus_b.wr1_addr_i = 4'd8;
    bus_b.wr1_data_i = vb[8];
    bus_b.rd_addr_i  = {4'd8, 4'd15, 4'd1, 4'd0};
    @(negedge clk);
    bus_b.wr0_en_i = 1'b0;
    bus_b.wr1_en_i = 1'b0;
    #1 check("b_r0_kept", bus_b.rd_data_o[63:0], vb[0]);
    check("b_r15", bus_b.rd_data_o[191:128], vb[15]);
    check("b_r8", bus_b.rd_data_o[255:192], vb[8]);
    check("b_no_conflict", 64'(bus_b.wr_conflict_o), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
